// File: rtl/vga_window_fetch.sv
// vga_window_fetch: VGA raster generator with a framebuffer-fetch window and latency-matched sync/colour.
// Define VGA_WINDOW_BORDER_EN to draw a 1-pixel 24'hFF8888 frame on the active-area edges.
module vga_window_fetch #(
   parameter int          PIX_W    = 8,
   parameter int          AW       = 18,
   parameter int          WIN_X    = 0,
   parameter int          WIN_Y    = 0,
   parameter int          WIN_W    = 300,
   parameter int          WIN_H    = 300,
   parameter int          RD_LAT   = 1,
   parameter logic [23:0] BG_COLOR = 24'h0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [11:0]      h_total,
   input  logic [11:0]      h_sync,
   input  logic [11:0]      h_start,
   input  logic [11:0]      h_end,
   input  logic [11:0]      v_total,
   input  logic [11:0]      v_sync,
   input  logic [11:0]      v_start,
   input  logic [11:0]      v_end,
   output logic             fb_rd_en,
   output logic [AW-1:0]    fb_addr,
   input  logic [PIX_W-1:0] fb_data,
   output logic             vga_hs,
   output logic             vga_vs,
   output logic             vga_de,
   output logic [7:0]       vga_r,
   output logic [7:0]       vga_g,
   output logic [7:0]       vga_b,
   output logic             frame_start
);
   localparam int pl = RD_LAT + 1;
   localparam logic [12:0] wx0 = 13'(WIN_X);
   localparam logic [12:0] wx1 = 13'(WIN_X + WIN_W);
   localparam logic [12:0] wy0 = 13'(WIN_Y);
   localparam logic [12:0] wy1 = 13'(WIN_Y + WIN_H);
   typedef struct packed {
      logic fs;
      logic hs;
      logic vs;
      logic de;
      logic win;
      logic brd;
   } tap_t;
   localparam tap_t idle = '{fs: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b0, win: 1'b0, brd: 1'b0};
   logic [11:0]   h_count, v_count;
   logic [12:0]   hx, vy;
   logic          h_wrap, v_wrap, act, in_win, first, border;
   logic [AW-1:0] addr_cnt, addr_now;
   logic [23:0]   pix, colour;
   tap_t          pipe [pl];
   tap_t          tap;
   always_comb begin
      h_wrap   = h_count >= h_total;
      v_wrap   = v_count >= v_total;
      act      = h_count >= h_start && h_count < h_end && v_count >= v_start && v_count < v_end;
      hx       = {1'b0, h_count - h_start};
      vy       = {1'b0, v_count - v_start};
      in_win   = act && hx >= wx0 && hx < wx1 && vy >= wy0 && vy < wy1;
      first    = h_count == 12'd0 && v_count == 12'd0;
      addr_now = first ? '0 : addr_cnt;
   end
`ifdef VGA_WINDOW_BORDER_EN
   assign border = act && (h_count == h_start || h_count == h_end - 12'd1 ||
                           v_count == v_start || v_count == v_end - 12'd1);
`else
   assign border = 1'b0;
`endif
   if (PIX_W == 8) begin : g_gray
      assign pix = {3{fb_data}};
   end else begin : g_rgb
      assign pix = fb_data[23:0];
   end
   // The last pipeline tap lines up with fb_data for the same raster position.
   always_comb begin
      tap    = pipe[pl-1];
      colour = !tap.de ? 24'h0 : tap.brd ? 24'hFF8888 : tap.win ? pix : BG_COLOR;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         h_count     <= '0;
         v_count     <= '0;
         addr_cnt    <= '0;
         fb_rd_en    <= 1'b0;
         fb_addr     <= '0;
         for (int i = 0; i < pl; i++) pipe[i] <= idle;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_de      <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         frame_start <= 1'b0;
      end else begin
         h_count  <= h_wrap ? '0 : h_count + 12'd1;
         if (h_wrap) v_count <= v_wrap ? '0 : v_count + 12'd1;
         addr_cnt <= addr_now + AW'(in_win);
         fb_rd_en <= in_win;
         fb_addr  <= addr_now;
         pipe[0]  <= '{fs: first, hs: h_count >= h_sync, vs: v_count >= v_sync, de: act, win: in_win, brd: border};
         for (int i = 1; i < pl; i++) pipe[i] <= pipe[i-1];
         vga_hs              <= tap.hs;
         vga_vs              <= tap.vs;
         vga_de              <= tap.de;
         frame_start         <= tap.fs;
         {vga_r, vga_g, vga_b} <= colour;
      end
endmodule

// File: tb/tb_vga_window_fetch.sv
// tb_vga_window_fetch: random raster timings against a raster-arithmetic reference model.
// Expected reads and output pixels are queued up front; a monitor pops and compares every cycle.
module tb_vga_window_fetch;
   localparam int          WX = 2, WY = 1, WW = 4, WH = 3, LAT = 3, AW = 18;
   localparam logic [23:0] BG = 24'h3C5A7E;
   localparam int          L  = LAT + 2;
   logic clk = 1'b0, reset_n = 1'b0;
   logic fb_rd_en, vga_hs, vga_vs, vga_de, frame_start;
   logic [AW-1:0] fb_addr;
   logic [7:0] fb_data, vga_r, vga_g, vga_b;
   logic [7:0] mem [256];
   logic [7:0] rdp [LAT];
   int ht, hsy, hst, hen, vt, vsy, vst, ven;
   int checks = 0, passes = 0, cyc = 0, n_cyc = 0;
   bit mon_en = 1'b0;
   logic [27:0] oq [$];
   int rq [$];
   always #5 clk = ~clk;
   vga_window_fetch #(.PIX_W(8), .AW(AW), .WIN_X(WX), .WIN_Y(WY), .WIN_W(WW), .WIN_H(WH),
                      .RD_LAT(LAT), .BG_COLOR(BG)) dut (
      .clk(clk), .reset_n(reset_n),
      .h_total(ht[11:0]), .h_sync(hsy[11:0]), .h_start(hst[11:0]), .h_end(hen[11:0]),
      .v_total(vt[11:0]), .v_sync(vsy[11:0]), .v_start(vst[11:0]), .v_end(ven[11:0]),
      .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_data(fb_data),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start));
   // Framebuffer: data for a read appears LAT cycles later; garbage when no read was issued.
   always @(posedge clk) begin
      rdp[0] <= fb_rd_en ? mem[fb_addr[7:0]] : 8'($urandom);
      for (int i = 1; i < LAT; i++) rdp[i] <= rdp[i-1];
   end
   assign fb_data = rdp[LAT-1];
   function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
      checks++;
      if (a === e) passes++;
      else $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
   endfunction
   // Reference: raster position from cycle index, address from window row/column and clipped width.
   task automatic model(input int k);
      int h, v, c, r, ew, a;
      bit act, win;
      logic [23:0] rgb;
      h   = k % (ht + 1);
      v   = (k / (ht + 1)) % (vt + 1);
      act = h >= hst && h < hen && v >= vst && v < ven;
      c   = h - hst;
      r   = v - vst;
      win = act && c >= WX && c < WX + WW && r >= WY && r < WY + WH;
      ew  = (hen - hst - WX < WW) ? hen - hst - WX : WW;
      a   = (r - WY) * ew + c - WX;
      rgb = 24'h0;
      if (act) rgb = win ? {3{mem[a[7:0]]}} : BG;
`ifdef VGA_WINDOW_BORDER_EN
      if (act && (h == hst || h == hen - 1 || v == vst || v == ven - 1)) rgb = 24'hFF8888;
`endif
      if (win) rq.push_back(a);
      oq.push_back({h == 0 && v == 0, h >= hsy, v >= vsy, act, rgb});
   endtask
   task automatic pick(input int c);
      if (c == 0) begin
         ht = 19; hsy = 2; hst = 4; hen = 16; vt = 9; vsy = 1; vst = 2; ven = 8;
      end else if (c == 1) begin
         ht = 19; hsy = 3; hst = 5; hen = 9; vt = 7; vsy = 1; vst = 1; ven = 4;
      end else begin
         ht  = int'($urandom_range(30, 6));
         hsy = int'($urandom_range(ht, 0));
         hst = int'($urandom_range(ht, 0));
         hen = (c % 4 == 3) ? int'($urandom_range(hst, 0)) : int'($urandom_range(ht + 1, hst + 1));
         vt  = int'($urandom_range(10, 3));
         vsy = int'($urandom_range(vt, 0));
         vst = int'($urandom_range(vt, 0));
         ven = int'($urandom_range(vt + 1, vst + 1));
      end
   endtask
   task automatic chk_reset();
      chk("reset_outputs", {fb_rd_en, fb_addr, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, frame_start},
          {1'b0, {AW{1'b0}}, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0});
   endtask
   always @(negedge clk)
      if (mon_en) begin
         logic [27:0] o;
         cyc++;
         if (cyc <= n_cyc && fb_rd_en) begin
            if (rq.size() == 0) chk("fb_rd_en_extra", 64'(fb_rd_en), 64'd0);
            else chk("fb_addr", 64'(fb_addr), 64'(rq.pop_front()));
         end
         if (oq.size() > 0) begin
            o = oq.pop_front();
            chk("pixel{fs,hs,vs,de,rgb}", 64'({frame_start, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b}), 64'(o));
         end
      end
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      pick(0);
      repeat (3) @(posedge clk);
      #1 chk_reset();
      for (int c = 0; c < 10; c++) begin
         int budget;
         pick(c);
         n_cyc = 2 * (ht + 1) * (vt + 1);
         for (int i = 0; i < L - 1; i++) oq.push_back({1'b0, 1'b1, 1'b1, 1'b0, 24'h0});
         for (int k = 0; k < n_cyc; k++) model(k);
         cyc = 0;
         @(negedge clk) reset_n = 1'b1;
         @(posedge clk) mon_en = 1'b1;
         budget = 0;
         while (oq.size() > 0 && budget < n_cyc + L + 20) begin
            @(posedge clk);
            budget++;
         end
         mon_en = 1'b0;
         if (oq.size() > 0) chk("output_timeout", 64'(oq.size()), 64'd0);
         chk("reads_left", 64'(rq.size()), 64'd0);
         oq.delete();
         rq.delete();
         repeat ($urandom_range(7, 1)) @(posedge clk);
         #3 reset_n = 1'b0;
         #1 chk_reset();
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
